// File: rtl/darkriscv_dbus_responder.sv
// Data-side memory model for the darkriscv core: word-addressed RAM with
// programmable wait states, byte-lane store merge, sticky protocol-error
// flag and saturating load/store transaction counters.
module darkriscv_dbus_responder #(
    parameter int unsigned AW   = 10,
    parameter int unsigned WAIT = 1
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    input  logic [3:0]  BE,
    input  logic        WR,
    input  logic        RD,
    output logic [31:0] DATAI,
    output logic        HLT,
    output logic        ERR,
    output logic [15:0] RDCNT,
    output logic [15:0] WRCNT
);

    localparam int unsigned DEPTH    = 2 ** AW;
    localparam int unsigned SHIFT    = AW + 2;
    localparam logic [7:0]  WAIT_CNT = 8'(WAIT);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    logic [31:0] mem [DEPTH];

    logic [7:0]    cnt_q,   cnt_d;
    logic [31:0]   hold_q,  hold_d;
    logic          err_q,   err_d;
    logic [15:0]   rdcnt_q, rdcnt_d;
    logic [15:0]   wrcnt_q, wrcnt_d;

    logic          req_c;
    logic          both_c;
    logic          last_c;
    logic          in_range_c;
    logic [AW-1:0] idx_c;
    logic [31:0]   rdata_c;

    // Decode the request, the implied access phase and the next-state values.
    always_comb begin
        req_c      = RD ^ WR;
        both_c     = RD & WR;
        in_range_c = (DADDR >> SHIFT) == 32'd0;
        idx_c      = DADDR[AW+1:2];
        last_c     = req_c && (cnt_q == WAIT_CNT);
        rdata_c    = in_range_c ? mem[idx_c] : 32'd0;

        cnt_d   = cnt_q;
        hold_d  = hold_q;
        err_d   = err_q;
        rdcnt_d = rdcnt_q;
        wrcnt_d = wrcnt_q;

        if (!req_c || last_c) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = 8'(cnt_q + 8'd1);
        end

        if (both_c) begin
            err_d = 1'b1;
        end

        if (last_c) begin
            if (!in_range_c) begin
                err_d = 1'b1;
            end
            if (RD) begin
                hold_d = rdata_c;
                if (rdcnt_q != CNT_MAX) begin
                    rdcnt_d = 16'(rdcnt_q + 16'd1);
                end
            end else begin
                if (wrcnt_q != CNT_MAX) begin
                    wrcnt_d = 16'(wrcnt_q + 16'd1);
                end
            end
        end
    end

    // Control and status registers; an in-flight access is dropped on reset.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            cnt_q   <= 8'd0;
            hold_q  <= 32'd0;
            err_q   <= 1'b0;
            rdcnt_q <= 16'd0;
            wrcnt_q <= 16'd0;
        end else begin
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            rdcnt_q <= rdcnt_d;
            wrcnt_q <= wrcnt_d;
        end
    end

    // Store commit: merge only the enabled byte lanes into the addressed word.
    always_ff @(posedge CLK) begin
        if (last_c && WR && in_range_c) begin
            for (int k = 0; k < 4; k++) begin
                if (BE[k]) begin
                    mem[idx_c][8*k +: 8] <= DATAO[8*k +: 8];
                end
            end
        end
    end

    // Stall while waiting; load data bypasses the holding register on completion.
    always_comb begin
        HLT   = RES && req_c && !last_c;
        DATAI = (last_c && RD) ? rdata_c : hold_q;
        ERR   = err_q;
        RDCNT = rdcnt_q;
        WRCNT = wrcnt_q;
    end

endmodule

// File: tb/tb_darkriscv_dbus_responder.sv
// Bench for darkriscv_dbus_responder: three instances (WAIT = 0, 2, 3) driven
// with directed and random accesses, checked against a word-array model.
module tb_darkriscv_dbus_responder;

    localparam int unsigned AW = 10;

    logic        clk;
    logic        rst_n [3];
    logic [31:0] daddr [3];
    logic [31:0] datao [3];
    logic [3:0]  be    [3];
    logic        wr    [3];
    logic        rd    [3];
    logic [31:0] datai [3];
    logic        hlt   [3];
    logic        err   [3];
    logic [15:0] rdcnt [3];
    logic [15:0] wrcnt [3];

    darkriscv_dbus_responder #(.AW(AW), .WAIT(0)) dut_w0 (
        .CLK(clk), .RES(rst_n[0]), .DADDR(daddr[0]), .DATAO(datao[0]), .BE(be[0]),
        .WR(wr[0]), .RD(rd[0]), .DATAI(datai[0]), .HLT(hlt[0]), .ERR(err[0]),
        .RDCNT(rdcnt[0]), .WRCNT(wrcnt[0]));

    darkriscv_dbus_responder #(.AW(AW), .WAIT(2)) dut_w2 (
        .CLK(clk), .RES(rst_n[1]), .DADDR(daddr[1]), .DATAO(datao[1]), .BE(be[1]),
        .WR(wr[1]), .RD(rd[1]), .DATAI(datai[1]), .HLT(hlt[1]), .ERR(err[1]),
        .RDCNT(rdcnt[1]), .WRCNT(wrcnt[1]));

    darkriscv_dbus_responder #(.AW(AW), .WAIT(3)) dut_w3 (
        .CLK(clk), .RES(rst_n[2]), .DADDR(daddr[2]), .DATAO(datao[2]), .BE(be[2]),
        .WR(wr[2]), .RD(rd[2]), .DATAI(datai[2]), .HLT(hlt[2]), .ERR(err[2]),
        .RDCNT(rdcnt[2]), .WRCNT(wrcnt[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state per instance
    logic [31:0] m_mem  [3][1024];
    int unsigned m_rd   [3];
    int unsigned m_wr   [3];
    logic        m_err  [3];
    logic [31:0] m_hold [3];

    int tests = 0;
    int fails = 0;

    function automatic int wait_of(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned n);
        return (v + n > 65535) ? 65535 : v + n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int i);
        wr[i] = 1'b0; rd[i] = 1'b0; be[i] = 4'h0; daddr[i] = 32'h0; datao[i] = 32'h0;
    endtask

    task automatic model_reset(input int i);
        m_rd[i] = 0; m_wr[i] = 0; m_err[i] = 1'b0; m_hold[i] = 32'h0;
    endtask

    task automatic chk_status(input int i, input string tag);
        chk({tag, "/err"},   32'(err[i]),   32'(m_err[i]));
        chk({tag, "/rdcnt"}, 32'(rdcnt[i]), m_rd[i]);
        chk({tag, "/wrcnt"}, 32'(wrcnt[i]), m_wr[i]);
        chk({tag, "/hold"},  datai[i],      m_hold[i]);
    endtask

    // One complete access; called at posedge+1, returns at posedge+1 after commit.
    task automatic access(input int i, input bit is_wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] b, input string tag);
        logic        oor;
        logic [31:0] exp;
        logic [31:0] w;
        oor = (addr[31:12] != 20'h0);
        daddr[i] = addr; datao[i] = data; be[i] = b;
        wr[i] = is_wr; rd[i] = !is_wr;
        for (int c = 0; c < wait_of(i); c++) begin
            @(negedge clk);
            chk({tag, "/hlt_wait"}, 32'(hlt[i]), 32'd1);
            step();
        end
        @(negedge clk);
        chk({tag, "/hlt_done"}, 32'(hlt[i]), 32'd0);
        exp = oor ? 32'h0 : m_mem[i][addr[11:2]];
        if (!is_wr) chk({tag, "/rdata"}, datai[i], exp);
        step();
        if (is_wr) begin
            if (!oor) begin
                w = m_mem[i][addr[11:2]];
                for (int k = 0; k < 4; k++)
                    if (b[k]) w[8*k +: 8] = data[8*k +: 8];
                m_mem[i][addr[11:2]] = w;
            end
            m_wr[i] = sat_inc(m_wr[i], 1);
        end else begin
            m_hold[i] = exp;
            m_rd[i] = sat_inc(m_rd[i], 1);
        end
        if (oor) m_err[i] = 1'b1;
        idle(i);
        #1;
        chk_status(i, tag);
    endtask

    task automatic random_phase(input int i, input int n);
        logic [31:0] a;
        for (int w = 0; w < 16; w++)
            access(i, 1'b1, 32'h200 + 32'(w * 4), $urandom, 4'hF, "rinit");
        for (int t = 0; t < n; t++) begin
            if ($urandom_range(0, 7) == 0)
                a = 32'h1000 | ($urandom & 32'hFFFF_FFFF);
            else
                a = 32'h200 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            access(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rand");
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            idle(i);
            model_reset(i);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset/hlt", 32'(hlt[i]), 32'd0);
            chk_status(i, "reset");
        end

        // WAIT=2 store then load
        step();
        access(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "w2_store");
        access(1, 1'b0, 32'h10, 32'h0, 4'hF, "w2_load");
        chk("w2_rdcnt_abs", 32'(rdcnt[1]), 32'd1);
        chk("w2_wrcnt_abs", 32'(wrcnt[1]), 32'd1);

        // Byte-lane merge
        access(1, 1'b1, 32'h20, 32'h11223344, 4'hF, "lane_full");
        access(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "lane_part");
        access(1, 1'b0, 32'h20, 32'h0, 4'hF, "lane_load");
        chk("lane_value", datai[1], 32'h11BB33DD);

        // WAIT=0 back-to-back
        for (int w = 0; w < 4; w++)
            access(0, 1'b1, 32'(w * 4), 32'hA5000000 + 32'(w), 4'hF, "w0_store");
        for (int w = 0; w < 4; w++)
            access(0, 1'b0, 32'(w * 4), 32'h0, 4'hF, "w0_load");
        chk("w0_rdcnt_abs", 32'(rdcnt[0]), 32'd4);

        // Out-of-range load
        chk("oor/err_before", 32'(err[1]), 32'd0);
        access(1, 1'b0, 32'h1000, 32'h0, 4'hF, "oor_load");
        chk("oor/err_after", 32'(err[1]), 32'd1);

        // RD and WR together after reset
        rst_n[1] = 1'b0;
        model_reset(1);
        step();
        rst_n[1] = 1'b1;
        daddr[1] = 32'h10; datao[1] = 32'h12345678; be[1] = 4'hF;
        rd[1] = 1'b1; wr[1] = 1'b1;
        @(negedge clk);
        chk("both/hlt", 32'(hlt[1]), 32'd0);
        step();
        idle(1);
        m_err[1] = 1'b1;
        #1;
        chk_status(1, "both");
        step();
        access(1, 1'b0, 32'h10, 32'h0, 4'hF, "both_mem");

        // Reset mid-access on WAIT=3
        access(2, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, "w3_store");
        daddr[2] = 32'h40; datao[2] = 32'h0BADBEEF; be[2] = 4'hF; wr[2] = 1'b1;
        @(negedge clk);
        chk("rst_mid/hlt_pre", 32'(hlt[2]), 32'd1);
        step();
        @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        chk("rst_mid/hlt_now", 32'(hlt[2]), 32'd0);
        idle(2);
        model_reset(2);
        step();
        rst_n[2] = 1'b1;
        #1;
        chk_status(2, "rst_mid");
        step();
        access(2, 1'b0, 32'h40, 32'h0, 4'hF, "rst_nocommit");

        // Request dropped while waiting
        daddr[2] = 32'h40; datao[2] = 32'h55555555; be[2] = 4'hF; wr[2] = 1'b1;
        @(negedge clk);
        chk("drop/hlt", 32'(hlt[2]), 32'd1);
        step();
        idle(2);
        step();
        access(2, 1'b0, 32'h40, 32'h0, 4'hF, "drop_load");

        // Randomized traffic
        random_phase(0, 40);
        random_phase(1, 40);
        random_phase(2, 20);

        // Store counter saturation with no-op stores
        daddr[0] = 32'h300; datao[0] = 32'hFFFFFFFF; be[0] = 4'h0; wr[0] = 1'b1;
        repeat (65537) step();
        idle(0);
        m_wr[0] = sat_inc(m_wr[0], 65537);
        #1;
        chk("sat/wrcnt", 32'(wrcnt[0]), 32'h0000FFFF);
        chk_status(0, "sat");
        step();
        access(0, 1'b1, 32'h300, 32'h0, 4'h0, "sat_hold");
        chk("sat/wrcnt_hold", 32'(wrcnt[0]), 32'h0000FFFF);
        access(0, 1'b0, 32'h200, 32'h0, 4'hF, "sat_mem");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/darkriscv_dbus_responder.md
# darkriscv_dbus_responder

Data-bus responder for the darkriscv core: the target end of the core's DADDR/DATAO/DATAI/BE/WR/RD interface. It holds a word-addressed register-file memory, services core loads and stores with a programmable number of wait states by driving HLT, and merges stores byte-lane by byte-lane. It flags protocol errors (RD and WR together, out-of-range address) and keeps saturating read/write transaction counts for debug. It instantiates beside the core in simulation and formal benches as the data-side memory model.

## Interface

Parameters:
- AW, 10: word-address width; memory depth is 2^AW 32-bit words (byte range 0 .. 2^(AW+2)-1).
- WAIT, 1: wait states per access, 0..255; each access occupies WAIT+1 cycles.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RES  in  1  reset, asynchronous, active-low (0 = reset).
- DADDR  in  32  byte address from core; bits [1:0] ignored; word index = DADDR[AW+1:2].
- DATAO  in  32  store data from core.
- BE  in  4  byte enables; BE[k] selects DATAO[8k+7:8k].
- WR  in  1  store request.
- RD  in  1  load request.
- DATAI  out  32  load data to core.
- HLT  out  1  stall to core; high while an access is waiting.
- ERR  out  1  sticky protocol-error flag.
- RDCNT  out  16  completed loads, saturating at 16'hFFFF.
- WRCNT  out  16  completed stores, saturating at 16'hFFFF.

## Operation

- Request = exactly one of RD/WR high. Core holds DADDR, DATAO, BE, RD/WR stable while HLT=1.
- Wait counter cnt (8 bits, 0 at reset). State is implied: idle when no request, WAITING when request and cnt<WAIT, COMPLETE when request and cnt==WAIT.
- WAITING: HLT=1; cnt increments on each clock.
- COMPLETE: HLT=0 (combinational from registered cnt and request); on this clock edge cnt returns to 0, store commits, RDCNT/WRCNT increment.
- Load complete: DATAI = mem[index] combinationally in the COMPLETE cycle; the value is latched into a holding register at that edge. In all other cycles DATAI = holding register.
- Store complete: for each k with BE[k]=1, mem[index] byte k <= DATAO byte k; other bytes unchanged. BE=0 is a valid no-op store (still counted).
- Out-of-range: DADDR[31:AW+2] != 0. Access still runs full wait timing; load returns 32'h0; store discarded; ERR set at completion.
- RD and WR both high: no access, HLT=0, cnt held at 0, no memory change, counters unchanged; ERR set on that clock edge.
- Request dropped while WAITING (protocol violation by core): cnt returns to 0 next edge, no commit, no ERR.
- Back-to-back: a request still present in the cycle after COMPLETE is a new access starting at cnt=0 (full WAIT+1 cycles again).
- WAIT=0: every request is COMPLETE in its first cycle; HLT never rises.
- Memory array is not reset; contents are undefined until written.

## Timing

- Reset (RES=0, async): cnt=0, HLT=0 immediately, DATAI holding register=0, ERR=0, RDCNT=0, WRCNT=0. Access in flight at reset is abandoned with no commit.
- Access latency: request first seen cycle T; HLT=1 in cycles T..T+WAIT-1; HLT=0 and data valid/commit in cycle T+WAIT.
- Store visible to a load whose COMPLETE cycle is after the store's commit edge (no same-cycle bypass needed; accesses are serialized).
- ERR sticky until reset. Counters saturate, never wrap.

## Test plan

- Reset: RES=0 mid-access with WAIT=3 -> HLT falls immediately; after release DATAI=0, ERR=0, RDCNT=WRCNT=0.
- WAIT=2: WR, DADDR=0x10, DATAO=0xDEADBEEF, BE=4'hF, then RD 0x10 -> HLT high 2 cycles each access; DATAI=0xDEADBEEF in load COMPLETE cycle; WRCNT=1, RDCNT=1.
- Byte lanes: store 0x11223344 BE=F to 0x20, then 0xAABBCCDD BE=4'b0101 -> load returns 0x11BB33DD.
- WAIT=0 back-to-back: RD on 4 consecutive cycles to 0x0,0x4,0x8,0xC -> HLT stays 0; correct word each cycle; RDCNT=4.
- Errors (AW=10): RD at 0x1000 -> returns 0 after full wait, ERR=1; RD=WR=1 for one cycle -> HLT=0, memory and counters unchanged, ERR=1.
- Saturation: force 65537 completed stores -> WRCNT=16'hFFFF, holds.
